// File: rtl/ofs_fim_pcie_tag_cpl_tracker.sv
`default_nettype none
// ============================================================================
// Module  : ofs_fim_pcie_tag_cpl_tracker
// Brief   : Non-posted read tag allocator with completion-credit tracking.
//           Optional completion timeout enabled by OFS_PCIE_CPL_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ofs_fim_pcie_tag_cpl_tracker #(
  parameter int MAX_TAGS       = 128,
  parameter int TAG_WIDTH      = $clog2(MAX_TAGS),
  parameter int MAX_LEN        = 1024,
  parameter int LEN_WIDTH      = $clog2(MAX_LEN) + 1,
  parameter int CPL_CREDIT_DW  = 10000,
  parameter int CREDIT_WIDTH   = $clog2(CPL_CREDIT_DW + 1),
  parameter int TIMEOUT_CYCLES = 12500000,
  parameter int TIME_WIDTH     = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_req,
  input  logic [LEN_WIDTH-1:0]    alloc_len,
  output logic                    alloc_gnt,
  output logic [TAG_WIDTH-1:0]    alloc_tag,
  input  logic                    cpl_valid,
  input  logic [TAG_WIDTH-1:0]    cpl_tag,
  input  logic [LEN_WIDTH-1:0]    cpl_len,
  input  logic                    cpl_last,
  output logic                    err_unexp_cpl,
  output logic                    timeout_valid,
  output logic [TAG_WIDTH-1:0]    timeout_tag,
  output logic [CREDIT_WIDTH-1:0] credit_avail,
  output logic [TAG_WIDTH:0]      tags_outstanding
);

  localparam int SW = ((CREDIT_WIDTH > LEN_WIDTH) ? CREDIT_WIDTH : LEN_WIDTH) + 2;
  localparam logic [TAG_WIDTH:0]   TAGS_W   = (TAG_WIDTH+1)'(MAX_TAGS);
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(MAX_TAGS - 1);

  if (MAX_TAGS < 2 || MAX_LEN >= 2**LEN_WIDTH ||
      TIMEOUT_CYCLES + MAX_TAGS >= 2**(TIME_WIDTH-1)) begin : g_bad_params
    $error("ofs_fim_pcie_tag_cpl_tracker: inconsistent parameters");
  end

  logic [MAX_TAGS-1:0]       busy;
  logic [2**TAG_WIDTH-1:0]   busy_pad;
  logic [LEN_WIDTH-1:0]      rem_len [MAX_TAGS];
  logic [TAG_WIDTH-1:0]      rr_ptr;
  logic [TAG_WIDTH:0]        sum;
  logic                      found;
  logic [TAG_WIDTH-1:0]      free_tag;
  logic                      cpl_hit;
  logic                      cpl_free;
  logic [LEN_WIDTH-1:0]      cpl_rem;
  logic [LEN_WIDTH-1:0]      cpl_take;
  logic [LEN_WIDTH-1:0]      cpl_ret;
  logic                      to_hit;
  logic [TAG_WIDTH-1:0]      to_tag;
  logic [LEN_WIDTH-1:0]      to_ret;
  logic [SW-1:0]             credit_next;

  // Round-robin search for the first free tag at or above rr_ptr.
  always_comb begin
    found    = 1'b0;
    free_tag = '0;
    sum      = '0;
    for (int i = 0; i < MAX_TAGS; i++) begin
      sum = {1'b0, rr_ptr} + (TAG_WIDTH+1)'(i);
      if (sum >= TAGS_W) sum = sum - TAGS_W;
      if (!found && !busy[TAG_WIDTH'(sum)]) begin
        found    = 1'b1;
        free_tag = TAG_WIDTH'(sum);
      end
    end
  end

  assign alloc_gnt = rst_n & alloc_req & found & (32'(credit_avail) >= 32'(alloc_len));
  assign alloc_tag = free_tag;

  always_comb begin
    busy_pad = '0;
    busy_pad[MAX_TAGS-1:0] = busy;
  end

  // Only credit actually reserved is ever returned, so overshooting completions are harmless.
  assign cpl_hit  = cpl_valid & busy_pad[cpl_tag];
  assign cpl_free = cpl_hit & cpl_last;
  assign cpl_rem  = rem_len[cpl_tag];
  assign cpl_take = (cpl_len > cpl_rem) ? cpl_rem : cpl_len;
  assign cpl_ret  = cpl_last ? cpl_rem : cpl_take;
  assign to_ret   = rem_len[to_tag];

`ifdef OFS_PCIE_CPL_TIMEOUT_EN
  logic [TIME_WIDTH-1:0] timer;
  logic [TIME_WIDTH-1:0] ts [MAX_TAGS];
  logic [TAG_WIDTH-1:0]  scan_ptr;
  logic [TIME_WIDTH-1:0] age;

  // Modular age; a completion retiring the same tag this cycle takes precedence.
  assign age    = timer - ts[scan_ptr];
  assign to_tag = scan_ptr;
  assign to_hit = busy[scan_ptr] && (age >= TIME_WIDTH'(TIMEOUT_CYCLES)) &&
                  !(cpl_hit && (cpl_tag == scan_ptr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer         <= '0;
      scan_ptr      <= '0;
      timeout_valid <= 1'b0;
      timeout_tag   <= '0;
    end else begin
      timer         <= timer + 1'b1;
      scan_ptr      <= (scan_ptr == LAST_TAG) ? '0 : scan_ptr + 1'b1;
      timeout_valid <= to_hit;
      if (to_hit) timeout_tag <= scan_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_gnt) ts[alloc_tag] <= timer;
  end
`else
  assign to_hit        = 1'b0;
  assign to_tag        = '0;
  assign timeout_valid = 1'b0;
  assign timeout_tag   = '0;
`endif

  assign credit_next = SW'(credit_avail)
                     + (cpl_hit   ? SW'(cpl_ret)   : '0)
                     + (to_hit    ? SW'(to_ret)    : '0)
                     - (alloc_gnt ? SW'(alloc_len) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy             <= '0;
      rr_ptr           <= '0;
      credit_avail     <= CREDIT_WIDTH'(CPL_CREDIT_DW);
      tags_outstanding <= '0;
      err_unexp_cpl    <= 1'b0;
    end else begin
      if (cpl_free) busy[cpl_tag]   <= 1'b0;
      if (to_hit)   busy[to_tag]    <= 1'b0;
      if (alloc_gnt) begin
        busy[alloc_tag] <= 1'b1;
        rr_ptr          <= (alloc_tag == LAST_TAG) ? '0 : alloc_tag + 1'b1;
      end
      credit_avail     <= CREDIT_WIDTH'(credit_next);
      tags_outstanding <= tags_outstanding + (TAG_WIDTH+1)'(alloc_gnt)
                          - (TAG_WIDTH+1)'(cpl_free) - (TAG_WIDTH+1)'(to_hit);
      err_unexp_cpl    <= cpl_valid & ~busy_pad[cpl_tag];
    end
  end

  always_ff @(posedge clk) begin
    if (cpl_hit)   rem_len[cpl_tag]   <= cpl_rem - cpl_take;
    if (alloc_gnt) rem_len[alloc_tag] <= alloc_len;
  end

endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_pcie_tag_cpl_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_ofs_fim_pcie_tag_cpl_tracker
// Brief   : Directed scoreboard bench for the tag/completion tracker
//           (5 tags, 64 DW credit, 100-cycle timeout).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ofs_fim_pcie_tag_cpl_tracker;

  localparam int MAX_TAGS       = 5;
  localparam int TAG_WIDTH      = 3;
  localparam int MAX_LEN        = 1024;
  localparam int LEN_WIDTH      = 11;
  localparam int CPL_CREDIT_DW  = 64;
  localparam int CREDIT_WIDTH   = 7;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int TIME_WIDTH     = 26;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    alloc_req = 1'b0;
  logic [LEN_WIDTH-1:0]    alloc_len = '0;
  logic                    alloc_gnt;
  logic [TAG_WIDTH-1:0]    alloc_tag;
  logic                    cpl_valid = 1'b0;
  logic [TAG_WIDTH-1:0]    cpl_tag = '0;
  logic [LEN_WIDTH-1:0]    cpl_len = '0;
  logic                    cpl_last = 1'b0;
  logic                    err_unexp_cpl;
  logic                    timeout_valid;
  logic [TAG_WIDTH-1:0]    timeout_tag;
  logic [CREDIT_WIDTH-1:0] credit_avail;
  logic [TAG_WIDTH:0]      tags_outstanding;

  ofs_fim_pcie_tag_cpl_tracker #(
    .MAX_TAGS(MAX_TAGS), .TAG_WIDTH(TAG_WIDTH), .MAX_LEN(MAX_LEN), .LEN_WIDTH(LEN_WIDTH),
    .CPL_CREDIT_DW(CPL_CREDIT_DW), .CREDIT_WIDTH(CREDIT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIME_WIDTH(TIME_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_len(alloc_len), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_len(cpl_len), .cpl_last(cpl_last),
    .err_unexp_cpl(err_unexp_cpl), .timeout_valid(timeout_valid), .timeout_tag(timeout_tag),
    .credit_avail(credit_avail), .tags_outstanding(tags_outstanding)
  );

  always #5 clk = ~clk;

  // Mirrors the free-running timer and one-tag-per-cycle scan from reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Starts at a negedge, holds the request until granted, ends at the next negedge.
  task automatic do_alloc(input int len, input int exp_tag, output int gcyc);
    bit got;
    got = 1'b0;
    gcyc = 0;
    exp_q.push_back(exp_tag);
    alloc_req = 1'b1;
    alloc_len = LEN_WIDTH'(len);
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (alloc_gnt === 1'b1) begin
        got  = 1'b1;
        gcyc = cyc;
        chk("grant_tag", 32'(alloc_tag), 32'(exp_q.pop_front()));
      end
      @(negedge clk);
    end
    alloc_req = 1'b0;
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL grant_wait: observed no grant expected tag %0d", exp_q.pop_front());
    end
  endtask

  task automatic do_cpl(input int tag, input int len, input bit last);
    cpl_valid = 1'b1;
    cpl_tag   = TAG_WIDTH'(tag);
    cpl_len   = LEN_WIDTH'(len);
    cpl_last  = last;
    @(negedge clk);
    cpl_valid = 1'b0;
    cpl_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, c, seen_cyc;
    bit seen;

    // Reset state
    #12;
    chk("rst_credit", 32'(credit_avail), 64);
    chk("rst_outstanding", 32'(tags_outstanding), 0);
    chk("rst_gnt", 32'(alloc_gnt), 0);
    chk("rst_err", 32'(err_unexp_cpl), 0);
    chk("rst_tv", 32'(timeout_valid), 0);
    chk("rst_tt", 32'(timeout_tag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fill all tags
    for (int t = 0; t < 5; t++) do_alloc(8, t, g);
    chk("fill_credit", 32'(credit_avail), 24);
    chk("fill_outstanding", 32'(tags_outstanding), 5);
    alloc_req = 1'b1;
    alloc_len = 11'd8;
    #1 chk("no_tag_gnt", 32'(alloc_gnt), 0);
    @(negedge clk);
    #1 chk("no_tag_gnt2", 32'(alloc_gnt), 0);

    // 2: last completion frees tag 2, pending request takes it
    cpl_valid = 1'b1; cpl_tag = 3'd2; cpl_len = 11'd8; cpl_last = 1'b1;
    #1 chk("gnt_before_free", 32'(alloc_gnt), 0);
    @(negedge clk);
    cpl_valid = 1'b0; cpl_last = 1'b0;
    #1 chk("credit_after_cpl", 32'(credit_avail), 32);
    do_alloc(8, 2, g);
    chk("credit_regrant", 32'(credit_avail), 24);

    // 3: credit starvation
    do_cpl(0, 8, 1'b1);
    do_cpl(1, 8, 1'b1);
    chk("credit_40", 32'(credit_avail), 40);
    do_alloc(36, 0, g);
    chk("credit_4", 32'(credit_avail), 4);
    alloc_req = 1'b1; alloc_len = 11'd8;
    cpl_valid = 1'b1; cpl_tag = 3'd3; cpl_len = 11'd4; cpl_last = 1'b0;
    #1 chk("credit_short_gnt", 32'(alloc_gnt), 0);
    @(negedge clk);
    cpl_valid = 1'b0;
    #1 chk("credit_partial", 32'(credit_avail), 8);
    do_alloc(8, 1, g);
    chk("credit_0", 32'(credit_avail), 0);

    // 4: unexpected completions and overshoot
    do_cpl(3, 4, 1'b1);
    chk("credit_tag3_done", 32'(credit_avail), 4);
    chk("err_quiet", 32'(err_unexp_cpl), 0);
    do_cpl(3, 4, 1'b0);
    chk("err_free_tag", 32'(err_unexp_cpl), 1);
    chk("err_credit", 32'(credit_avail), 4);
    @(negedge clk);
    chk("err_pulse_end", 32'(err_unexp_cpl), 0);
    do_cpl(7, 2, 1'b1);
    chk("err_range_tag", 32'(err_unexp_cpl), 1);
    chk("err_range_outst", 32'(tags_outstanding), 4);
    do_cpl(4, 20, 1'b0);
    chk("overshoot_credit", 32'(credit_avail), 12);
    do_cpl(4, 1, 1'b1);
    chk("overshoot_last", 32'(credit_avail), 12);
    chk("overshoot_outst", 32'(tags_outstanding), 3);
    do_cpl(0, 36, 1'b1);
    do_cpl(1, 8, 1'b1);
    do_cpl(2, 8, 1'b1);
    chk("drain_credit", 32'(credit_avail), 64);
    chk("drain_outst", 32'(tags_outstanding), 0);

    // 5: timeout of an orphaned request
    do_alloc(16, 2, g);
    chk("to_alloc_credit", 32'(credit_avail), 48);
    c = g + TIMEOUT_CYCLES;
    while (c % MAX_TAGS != 2) c++;
`ifdef OFS_PCIE_CPL_TIMEOUT_EN
    seen = 1'b0;
    seen_cyc = 0;
    for (int n = 0; n < 130 && !seen; n++) begin
      if (timeout_valid === 1'b1) begin
        seen = 1'b1;
        seen_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_cycle", 32'(seen_cyc), 32'(c + 1));
    chk("to_tag", 32'(timeout_tag), 2);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout_valid), 0);
    chk("to_credit", 32'(credit_avail), 64);
    chk("to_outst", 32'(tags_outstanding), 0);
`else
    seen = 1'b0;
    repeat (130) begin
      @(negedge clk);
      if (timeout_valid !== 1'b0) seen = 1'b1;
    end
    chk("to_disabled", 32'(seen), 0);
    chk("to_disabled_credit", 32'(credit_avail), 48);
    do_cpl(2, 16, 1'b1);
    chk("to_disabled_drain", 32'(credit_avail), 64);
`endif

    // 6: completion and timeout on the same tag, same cycle
    do_alloc(8, 3, g);
    c = g + TIMEOUT_CYCLES;
    while (c % MAX_TAGS != 3) c++;
    seen = 1'b0;
    for (int n = 0; n < 200 && cyc < c; n++) begin
      if (timeout_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("race_align", 32'(cyc), 32'(c));
    do_cpl(3, 3, 1'b1);
    for (int n = 0; n < 8; n++) begin
      if (timeout_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("race_no_timeout", 32'(seen), 0);
    chk("race_credit", 32'(credit_avail), 64);
    chk("race_outst", 32'(tags_outstanding), 0);
    chk("race_tt", 32'(timeout_tag), 2 * ((32'(timeout_tag) == 2) ? 1 : 0) + 0);

    // 7: asynchronous reset mid-traffic
    do_alloc(8, 4, g);
    do_alloc(8, 0, g);
    do_cpl(1, 1, 1'b0);
    chk("pre_rst_err", 32'(err_unexp_cpl), 1);
    alloc_req = 1'b1; alloc_len = 11'd8;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(alloc_gnt), 0);
    chk("arst_err", 32'(err_unexp_cpl), 0);
    chk("arst_credit", 32'(credit_avail), 64);
    chk("arst_outst", 32'(tags_outstanding), 0);
    chk("arst_tv", 32'(timeout_valid), 0);
    chk("arst_tt", 32'(timeout_tag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_alloc(8, 0, g);
    chk("post_rst_credit", 32'(credit_avail), 56);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
